dpram_pipe: RTL and testbench
=============================

DPRAM_PIPE -- requirements
Module: dpram_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5: address width.
REQ-003 SHALL have parameter DEPTH, default 24: number of words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency, legal values 1 or 2.
REQ-005 SHALL have parameter COLL_MODE, default 0: 0 = write-first, 1 = read-first.
REQ-006 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port enb  in  1  global enable for new requests.
REQ-009 SHALL have port wr  in  1  write request.
REQ-010 SHALL have port w_addr  in  ADDR_W  write address.
REQ-011 SHALL have port w_data  in  DATA_W  write data.
REQ-012 SHALL have port w_be  in  DATA_W/8  byte enables; bit k covers bits [8k+7:8k].
REQ-013 SHALL have port rd  in  1  read request.
REQ-014 SHALL have port r_addr  in  ADDR_W  read address.
REQ-015 SHALL have port clr  in  1  start memory clear.
REQ-016 SHALL have port r_data  out  DATA_W  read data; holds last value between valid reads.
REQ-017 SHALL have port r_valid  out  1  one-cycle strobe qualifying r_data.
REQ-018 SHALL have port busy  out  1  clear in progress.
REQ-019 SHALL have port err_oor  out  1  one-cycle out-of-range address strobe.

Function
REQ-020 SHALL implement FSM states IDLE and CLEAR; reset enters CLEAR with clear pointer 0.
REQ-021 In CLEAR, SHALL write all-zero to word [pointer] each cycle, increment it, and go to IDLE after word DEPTH-1 (DEPTH cycles total); busy = 1 exactly while in CLEAR.
REQ-022 In IDLE, clr = 1 SHALL enter CLEAR with pointer 0 next cycle; clr in CLEAR SHALL be ignored (no restart).
REQ-023 While busy, wr/rd SHALL be ignored: no write, no r_valid, no err_oor.
REQ-024 Request accepted only when state IDLE, enb = 1 and clr = 0; otherwise wr/rd ignored.
REQ-025 Accepted write at in-range address SHALL update only bytes with w_be = 1; w_be = 0 writes nothing.
REQ-026 Accepted read SHALL raise r_valid and update r_data exactly RD_LAT cycles after the sampling edge; back-to-back reads SHALL give back-to-back r_valid.
REQ-027 In-flight reads (RD_LAT = 2) SHALL complete even if enb drops or clr is applied afterward.
REQ-028 Collision (accepted wr and rd, same in-range address): COLL_MODE 0 SHALL return old word merged with w_data under w_be; COLL_MODE 1 SHALL return old word; memory SHALL be updated in both modes.
REQ-029 Address >= DEPTH: write SHALL be dropped; read SHALL return all-zero with normal r_valid timing; err_oor SHALL pulse for one cycle, the cycle after the sampling edge; both ports bad in one cycle give a single pulse.
REQ-030 Simultaneous accepted wr and rd to different addresses SHALL both complete independently.

Reset
REQ-031 rstn = 0 at a clock edge SHALL set r_data = 0, r_valid = 0, err_oor = 0, flush the read pipeline, and set state CLEAR, pointer 0 (busy = 1 the next cycle).
REQ-032 Reset asserted mid-CLEAR or mid-read SHALL restart the clear from pointer 0 and discard pending reads.

Verification
REQ-033 Reset, then wait: busy = 1 for exactly 24 cycles, then 0; reading addresses 0..23 returns 0x0000 with r_valid.
REQ-034 Write 0xABCD to addr 5 with w_be = 2'b11, then w_data 0x1234 with w_be = 2'b01; read addr 5 -> r_data = 0xAB34, r_valid one cycle after the read edge (RD_LAT = 1), two cycles after with RD_LAT = 2.
REQ-035 Addr 7 holds 0x1111; same cycle write 0x2222 (w_be = 2'b11) and read addr 7 -> r_data 0x2222 (COLL_MODE 0) or 0x1111 (COLL_MODE 1); subsequent read returns 0x2222.
REQ-036 Write addr 30 with 0xFFFF, then read addr 30 -> err_oor pulses on each; read returns 0x0000; addresses 0..23 unchanged.
REQ-037 clr pulse while issuing reads/writes -> busy for 24 cycles, requests ignored, no r_valid; an RD_LAT = 2 read launched before clr still completes.
REQ-038 rstn low for one cycle during clear at pointer 10 -> busy stays high for a full 24 cycles from release; r_valid stays 0.

Source files
------------

// File: rtl/dpram_pipe.sv
// Simple dual-port RAM with byte-enabled writes, pipelined reads (RD_LAT 1 or 2),
// configurable write/read collision behaviour and a sequential zero-fill clear engine.
module dpram_pipe #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 24,
  parameter int RD_LAT    = 1,
  parameter int COLL_MODE = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enb,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   r_addr,
  input  logic                clr,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_valid,
  output logic                busy,
  output logic                err_oor
);

  localparam int              NB      = DATA_W / 8;
  localparam logic [0:0]      IDLE    = 1'b0;
  localparam logic [0:0]      CLEAR   = 1'b1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [RD_LAT:1]             vld_pipe_q;
  logic [RD_LAT:1][DATA_W-1:0] data_pipe_q;
  logic                        err_q;

  logic              accept, w_in, r_in, wr_ok, rd_acc, coll;
  logic [DATA_W-1:0] mask, old_word, merged, rd_word;

  assign accept = (state_q == IDLE) & enb & ~clr;
  assign w_in   = {1'b0, w_addr} < DEPTH_C;
  assign r_in   = {1'b0, r_addr} < DEPTH_C;
  assign wr_ok  = accept & wr & w_in;
  assign rd_acc = accept & rd;
  assign coll   = wr_ok & rd_acc & r_in & (w_addr == r_addr);

  always_comb begin
    mask = '0;
    for (int k = 0; k < NB; k++) mask[8*k +: 8] = {8{w_be[k]}};
  end

  // Out-of-range reads return zero; a write-first collision sees the byte-merged word.
  assign old_word = r_in ? mem_q[r_addr] : '0;
  assign merged   = (old_word & ~mask) | (w_data & mask);
  assign rd_word  = (coll && COLL_MODE == 0) ? merged : old_word;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (clr) begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
      default: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_C) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      if (state_q == CLEAR) mem_q[ptr_q] <= '0;
      else if (wr_ok)       mem_q[w_addr] <= (mem_q[w_addr] & ~mask) | (w_data & mask);
    end
  end

  // Read pipeline runs independently of the FSM so in-flight reads survive a clr.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
      err_q       <= 1'b0;
    end else begin
      vld_pipe_q[1] <= rd_acc;
      if (rd_acc) data_pipe_q[1] <= rd_word;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        if (vld_pipe_q[i-1]) data_pipe_q[i] <= data_pipe_q[i-1];
      end
      err_q <= accept & ((wr & ~w_in) | (rd & ~r_in));
    end
  end

  assign r_valid = vld_pipe_q[RD_LAT];
  assign r_data  = data_pipe_q[RD_LAT];
  assign busy    = (state_q == CLEAR);
  assign err_oor = err_q;

endmodule

// File: tb/tb_dpram_pipe.sv
// Directed bench: two instances share stimulus, u0 = RD_LAT 1 / write-first,
// u1 = RD_LAT 2 / read-first.
module tb_dpram_pipe;
  logic        clk = 1'b0;
  logic        rstn, enb, wr, rd, clr;
  logic [4:0]  w_addr, r_addr;
  logic [15:0] w_data;
  logic [1:0]  w_be;
  logic [15:0] r0_data, r1_data;
  logic        r0_valid, r1_valid, busy0, busy1, err0, err1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dpram_pipe u0 (
    .clk(clk), .rstn(rstn), .enb(enb), .wr(wr), .w_addr(w_addr), .w_data(w_data),
    .w_be(w_be), .rd(rd), .r_addr(r_addr), .clr(clr),
    .r_data(r0_data), .r_valid(r0_valid), .busy(busy0), .err_oor(err0));

  dpram_pipe #(.RD_LAT(2), .COLL_MODE(1)) u1 (
    .clk(clk), .rstn(rstn), .enb(enb), .wr(wr), .w_addr(w_addr), .w_data(w_data),
    .w_be(w_be), .rd(rd), .r_addr(r_addr), .clr(clr),
    .r_data(r1_data), .r_valid(r1_valid), .busy(busy1), .err_oor(err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
    wr = 1'b1; w_addr = a; w_data = d; w_be = be;
    tick;
    wr = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [4:0] a, input logic [15:0] exp);
    rd = 1'b1; r_addr = a;
    tick;
    rd = 1'b0;
    chk({tag, "_v0"}, r0_valid, 1);
    chk({tag, "_d0"}, r0_data, exp);
    chk({tag, "_v1_early"}, r1_valid, 0);
    tick;
    chk({tag, "_v1"}, r1_valid, 1);
    chk({tag, "_d1"}, r1_data, exp);
    chk({tag, "_v0_off"}, r0_valid, 0);
  endtask

  task automatic count_busy(input string tag, input logic hold_req);
    int n = 0;
    int bad = 0;
    rd = hold_req; wr = hold_req; r_addr = 5'd30; w_addr = 5'd9; w_data = 16'h7777; w_be = 2'b11;
    while (busy0 && n < 100) begin
      clr = (n == 3);
      tick;
      n++;
      if (r0_valid || r1_valid || err0 || err1) bad++;
    end
    clr = 1'b0; rd = 1'b0; wr = 1'b0;
    chk({tag, "_busy_cycles"}, n, 24);
    chk({tag, "_quiet"}, bad, 0);
    chk({tag, "_busy1_done"}, busy1, 0);
  endtask

  initial begin
    rstn = 1'b0; enb = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0;
    w_addr = '0; r_addr = '0; w_data = '0; w_be = '0;

    // Reset and initial clear
    tick;
    chk("rst_busy", busy0, 1);
    chk("rst_valid", r0_valid, 0);
    chk("rst_data", r0_data, 0);
    chk("rst_err", err0, 0);
    rstn = 1'b1;
    count_busy("init", 1'b0);

    // Back-to-back reads of the cleared array
    for (int a = 0; a < 24; a++) begin
      rd = 1'b1; r_addr = 5'(a);
      tick;
      chk("clr_v0", r0_valid, 1);
      chk("clr_d0", r0_data, 0);
      chk("clr_v1", r1_valid, a > 0);
    end
    rd = 1'b0;
    tick;
    chk("b2b_v0_end", r0_valid, 0);
    chk("b2b_v1_last", r1_valid, 1);
    chk("b2b_d1_last", r1_data, 0);
    tick;
    chk("b2b_v1_end", r1_valid, 0);

    // Byte enables
    do_write(5'd5, 16'hABCD, 2'b11);
    do_write(5'd5, 16'h1234, 2'b01);
    do_read("be_merge", 5'd5, 16'hAB34);
    do_write(5'd5, 16'hFFFF, 2'b00);
    do_read("be_none", 5'd5, 16'hAB34);

    // Collision
    do_write(5'd7, 16'h1111, 2'b11);
    wr = 1'b1; w_addr = 5'd7; w_data = 16'h2222; w_be = 2'b11; rd = 1'b1; r_addr = 5'd7;
    tick;
    wr = 1'b0; rd = 1'b0;
    chk("coll_d0_wfirst", r0_data, 16'h2222);
    chk("coll_v0", r0_valid, 1);
    tick;
    chk("coll_d1_rfirst", r1_data, 16'h1111);
    chk("coll_v1", r1_valid, 1);
    do_read("coll_after", 5'd7, 16'h2222);

    // Independent write and read to different addresses
    wr = 1'b1; w_addr = 5'd8; w_data = 16'h5A5A; w_be = 2'b11; rd = 1'b1; r_addr = 5'd5;
    tick;
    wr = 1'b0; rd = 1'b0;
    chk("dual_d0", r0_data, 16'hAB34);
    tick;
    chk("dual_d1", r1_data, 16'hAB34);
    do_read("dual_wr", 5'd8, 16'h5A5A);

    // Out-of-range accesses
    do_write(5'd30, 16'hFFFF, 2'b11);
    chk("oor_wr_err0", err0, 1);
    chk("oor_wr_err1", err1, 1);
    tick;
    chk("oor_wr_err_off", err0, 0);
    rd = 1'b1; r_addr = 5'd30;
    tick;
    rd = 1'b0;
    chk("oor_rd_err", err0, 1);
    chk("oor_rd_v0", r0_valid, 1);
    chk("oor_rd_d0", r0_data, 0);
    tick;
    chk("oor_rd_err_off", err1, 0);
    chk("oor_rd_d1", r1_data, 0);
    wr = 1'b1; w_addr = 5'd31; rd = 1'b1; r_addr = 5'd30;
    tick;
    wr = 1'b0; rd = 1'b0;
    chk("oor_both_err", err0, 1);
    tick;
    chk("oor_both_single", err0, 0);
    tick;
    do_read("oor_keep5", 5'd5, 16'hAB34);
    do_read("oor_keep7", 5'd7, 16'h2222);
    do_read("oor_keep0", 5'd0, 16'h0000);

    // Global enable low blocks requests
    enb = 1'b0;
    do_write(5'd9, 16'h9999, 2'b11);
    rd = 1'b1; r_addr = 5'd5;
    tick;
    rd = 1'b0;
    chk("enb_no_v0", r0_valid, 0);
    tick;
    chk("enb_no_v1", r1_valid, 0);
    enb = 1'b1;
    do_read("enb_no_wr", 5'd9, 16'h0000);

    // clr while traffic is flowing; in-flight RD_LAT=2 read still completes
    rd = 1'b1; r_addr = 5'd5;
    tick;
    chk("pre_clr_d0", r0_data, 16'hAB34);
    clr = 1'b1; r_addr = 5'd7; wr = 1'b1; w_addr = 5'd9; w_data = 16'h7777; w_be = 2'b11;
    tick;
    clr = 1'b0;
    chk("clr_busy", busy0, 1);
    chk("clr_blocks_rd", r0_valid, 0);
    chk("clr_inflight_v1", r1_valid, 1);
    chk("clr_inflight_d1", r1_data, 16'hAB34);
    count_busy("clr", 1'b1);
    do_read("clr_wr_ignored", 5'd9, 16'h0000);
    do_read("clr_zeroed", 5'd5, 16'h0000);

    // Reset discards a pending read and zeroes r_data
    do_write(5'd3, 16'hBEEF, 2'b11);
    rd = 1'b1; r_addr = 5'd3;
    tick;
    chk("rstrd_d0", r0_data, 16'hBEEF);
    rd = 1'b0; rstn = 1'b0;
    tick;
    rstn = 1'b1;
    chk("rstrd_d0_zero", r0_data, 0);
    chk("rstrd_v1_flushed", r1_valid, 0);
    chk("rstrd_busy", busy1, 1);
    count_busy("rstrd", 1'b0);

    // Reset mid-clear at pointer 10 restarts the full clear
    clr = 1'b1;
    tick;
    clr = 1'b0;
    repeat (10) tick;
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    count_busy("rstclr", 1'b1);
    do_read("final", 5'd3, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
